// File: rtl/adder_server.sv
// Round-robin multi-channel add/sub server with a stallable result pipeline.
// Optional saturation on signed overflow.
module adder_server #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 4,
    parameter int LAT   = 2,
    parameter int SAT   = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_CH-1:0]           i_req_valid,
    output logic [N_CH-1:0]           o_req_ready,
    input  logic [N_CH*WIDTH-1:0]     i_req_a,
    input  logic [N_CH*WIDTH-1:0]     i_req_b,
    input  logic [N_CH-1:0]           i_req_sub,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [WIDTH-1:0]          o_rsp_sum,
    output logic [$clog2(N_CH)-1:0]   o_rsp_ch,
    output logic                      o_rsp_ovf,
    output logic                      o_busy
);

    localparam int CW = $clog2(N_CH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [LAT-1:0]   r_vld;
    logic [WIDTH-1:0] r_sum [LAT];
    logic [CW-1:0]    r_ch  [LAT];
    logic [LAT-1:0]   r_ovf;
    logic [CW-1:0]    r_rr_ptr;

    logic             w_adv;
    logic             w_any;
    logic             w_acc;
    logic [CW-1:0]    w_gnt;
    logic [CW-1:0]    w_idx;
    int               w_k;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_sub;
    logic [WIDTH:0]   w_ext;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum;

    assign w_adv = !o_rsp_valid || i_rsp_ready;

    // Scan from the highest offset down so the nearest valid channel wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        w_k   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_k = int'(r_rr_ptr) + i;
            if (w_k >= N_CH) w_k = w_k - N_CH;
            w_idx = CW'(w_k);
            if (i_req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    assign w_acc = w_adv && w_any && i_rst_n;

    always_comb begin
        o_req_ready = '0;
        if (w_acc) o_req_ready = N_CH'(1) << w_gnt;
    end

    assign w_a   = i_req_a[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_b   = i_req_b[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_sub = i_req_sub[w_gnt];

    always_comb begin
        if (w_sub) w_ext = {w_a[WIDTH-1], w_a} - {w_b[WIDTH-1], w_b};
        else       w_ext = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
        w_ovf = w_ext[WIDTH] ^ w_ext[WIDTH-1];
        w_sum = w_ext[WIDTH-1:0];
        if (SAT != 0 && w_ovf) w_sum = w_ext[WIDTH] ? SMIN : SMAX;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= '0;
            r_ovf    <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_sum[i] <= '0;
                r_ch[i]  <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= w_acc;
            r_sum[0] <= w_acc ? w_sum : '0;
            r_ch[0]  <= w_acc ? w_gnt : '0;
            r_ovf[0] <= w_acc && w_ovf;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_sum[i] <= r_sum[i-1];
                r_ch[i]  <= r_ch[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
            if (w_acc) begin
                if (w_gnt == CW'(N_CH - 1)) r_rr_ptr <= '0;
                else                        r_rr_ptr <= w_gnt + 1'b1;
            end
        end
    end

    assign o_rsp_valid = r_vld[LAT-1];
    assign o_rsp_sum   = r_sum[LAT-1];
    assign o_rsp_ch    = r_ch[LAT-1];
    assign o_rsp_ovf   = r_ovf[LAT-1];
    assign o_busy      = |r_vld;

endmodule

// File: tb/tb_adder_server.sv
// Scoreboard bench for adder_server: one wrapping and one saturating
// instance share stimulus; a reference model predicts every response.
module tb_adder_server;

    parameter int WIDTH = 32;
    parameter int N_CH  = 4;
    parameter int LAT   = 2;

    localparam int CW = $clog2(N_CH);

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] wr;
        logic [WIDTH-1:0] sr;
        logic             ov;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [N_CH-1:0]         req_valid;
    logic [N_CH*WIDTH-1:0]   req_a;
    logic [N_CH*WIDTH-1:0]   req_b;
    logic [N_CH-1:0]         req_sub;
    logic                    rsp_ready;

    logic [N_CH-1:0]  rdy0, rdy1;
    logic             val0, val1;
    logic [WIDTH-1:0] sum0, sum1;
    logic [CW-1:0]    ch0, ch1;
    logic             ovf0, ovf1;
    logic             busy0, busy1;

    adder_server #(.WIDTH(WIDTH), .N_CH(N_CH), .LAT(LAT), .SAT(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(rdy0),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
        .o_rsp_valid(val0), .i_rsp_ready(rsp_ready),
        .o_rsp_sum(sum0), .o_rsp_ch(ch0), .o_rsp_ovf(ovf0),
        .o_busy(busy0)
    );

    adder_server #(.WIDTH(WIDTH), .N_CH(N_CH), .LAT(LAT), .SAT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(rdy1),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
        .o_rsp_valid(val1), .i_rsp_ready(rsp_ready),
        .o_rsp_sum(sum1), .o_rsp_ch(ch1), .o_rsp_ovf(ovf1),
        .o_busy(busy1)
    );

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int ptr = 0;
    logic [N_CH-1:0] acc_seen = '0;
    exp_t q[$];

    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_s0, prev_s1;
    logic [CW-1:0]    prev_ch;
    logic             prev_ov0, prev_ov1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic, then wrap or clamp.
    function automatic exp_t model(input int c, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic sub);
        exp_t e;
        logic signed [71:0] one, sa, sb, t, mx, mn;
        one = 1;
        sa = 72'($signed(a));
        sb = 72'($signed(b));
        t  = sub ? sa - sb : sa + sb;
        mx = (one <<< (WIDTH - 1)) - one;
        mn = -(one <<< (WIDTH - 1));
        e.ch = c;
        e.ov = (t > mx) || (t < mn);
        e.wr = t[WIDTH-1:0];
        e.sr = e.ov ? ((t > mx) ? mx[WIDTH-1:0] : mn[WIDTH-1:0]) : t[WIDTH-1:0];
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op(input int pe);
        logic [63:0] r;
        logic [WIDTH-1:0] v;
        r = {$urandom(), $urandom()};
        v = r[WIDTH-1:0];
        if ($urandom_range(99) < pe) begin
            case ($urandom_range(4))
                0: v = '0;
                1: begin v = '1; v[WIDTH-1] = 1'b0; end
                2: begin v = '0; v[WIDTH-1] = 1'b1; end
                3: v = '1;
                default: v = WIDTH'(1);
            endcase
        end
        return v;
    endfunction

    // Monitor: arbiter model, occupancy, stability and scoreboard.
    always @(negedge clk) begin
        bit found;
        int g;
        logic [N_CH-1:0] exp_rdy;
        logic [N_CH-1:0] acc;
        exp_t h;
        if (!rst_n) begin
            chk(!val0 && !val1, "rst_valid", {val1, val0}, 0);
            chk(!busy0 && !busy1, "rst_busy", {busy1, busy0}, 0);
            chk(rdy0 == 0 && rdy1 == 0, "rst_ready", {rdy1, rdy0}, 0);
            chk(sum0 == 0 && ch0 == 0 && !ovf0, "rst_payload",
                {sum0, ch0, ovf0}, 0);
            q.delete();
            ptr = 0;
            acc_seen = '0;
            prev_stall = 0;
        end else begin
            chk(busy0 == (q.size() != 0), "busy", busy0, q.size() != 0);
            chk(busy1 == busy0, "busy_sat", busy1, busy0);
            found = 0;
            g = 0;
            for (int i = 0; i < N_CH; i++) begin
                int c;
                c = (ptr + i) % N_CH;
                if (!found && req_valid[c]) begin
                    found = 1;
                    g = c;
                end
            end
            exp_rdy = '0;
            if (found && (!val0 || rsp_ready)) exp_rdy = N_CH'(1) << g;
            chk(rdy0 == exp_rdy, "req_ready", rdy0, exp_rdy);
            chk(rdy1 == rdy0, "req_ready_sat", rdy1, rdy0);
            if (prev_stall) begin
                chk(val0 && sum0 == prev_s0 && ch0 == prev_ch && ovf0 == prev_ov0,
                    "stall_hold", {val0, sum0, ch0, ovf0},
                    {1'b1, prev_s0, prev_ch, prev_ov0});
                chk(val1 && sum1 == prev_s1 && ovf1 == prev_ov1,
                    "stall_hold_sat", {val1, sum1, ovf1},
                    {1'b1, prev_s1, prev_ov1});
            end
            chk(val1 == val0, "rsp_valid_sat", val1, val0);
            if (val0) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_rsp", {sum0, ch0}, 0);
                end else begin
                    h = q[0];
                    chk(int'(ch0) == h.ch && int'(ch1) == h.ch, "rsp_ch",
                        {ch1, ch0}, h.ch);
                    chk(sum0 == h.wr, "rsp_sum_wrap", sum0, h.wr);
                    chk(sum1 == h.sr, "rsp_sum_sat", sum1, h.sr);
                    chk(ovf0 == h.ov && ovf1 == h.ov, "rsp_ovf",
                        {ovf1, ovf0}, h.ov);
                    if (rsp_ready) void'(q.pop_front());
                end
            end
            prev_stall = val0 && !rsp_ready;
            prev_s0 = sum0;
            prev_s1 = sum1;
            prev_ch = ch0;
            prev_ov0 = ovf0;
            prev_ov1 = ovf1;
            acc = rdy0 & req_valid;
            acc_seen = acc;
            if (acc != 0) begin
                acc_cnt++;
                q.push_back(model(g, req_a[g*WIDTH +: WIDTH],
                                  req_b[g*WIDTH +: WIDTH], req_sub[g]));
                ptr = (g + 1) % N_CH;
            end
        end
    end

    // One cycle of requester behaviour: hold until accepted, then maybe renew.
    task automatic step(input int pv, input int pr, input int pe);
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (acc_seen[c] || !req_valid[c]) begin
                req_valid[c] = ($urandom_range(99) < pv);
                req_a[c*WIDTH +: WIDTH] = rnd_op(pe);
                req_b[c*WIDTH +: WIDTH] = rnd_op(pe);
                req_sub[c] = $urandom_range(1);
            end
        end
        rsp_ready = ($urandom_range(99) < pr);
    endtask

    task automatic idle();
        int n;
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy0 && n < 50);
        chk(!busy0, "drain_timeout", busy0, 0);
    endtask

    task automatic send1(input int c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub);
        int n;
        @(posedge clk);
        #1;
        req_valid = '0;
        req_valid[c] = 1'b1;
        req_a[c*WIDTH +: WIDTH] = a;
        req_b[c*WIDTH +: WIDTH] = b;
        req_sub[c] = sub;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!acc_seen[c] && n < 20);
        chk(acc_seen[c], "send_timeout", acc_seen, N_CH'(1) << c);
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
    endtask

    initial begin
        int n, a0;
        logic [WIDTH-1:0] mx, mn;
        mx = '1;
        mx[WIDTH-1] = 1'b0;
        mn = '0;
        mn[WIDTH-1] = 1'b1;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sub = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single request, latency measured from the accepting edge.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_a[WIDTH-1:0] = WIDTH'(5);
        req_b[WIDTH-1:0] = WIDTH'(7);
        req_sub[0] = 1'b0;
        @(negedge clk);
        #1;
        chk(acc_seen == N_CH'(1), "first_accept", acc_seen, 1);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            req_valid[0] = 1'b0;
            @(negedge clk);
            #1;
        end while (!val0 && n < 20);
        chk(n == LAT, "latency", n, LAT);
        chk(sum0 == WIDTH'(12) && ch0 == 0 && !ovf0, "sum_5_7",
            {sum0, ch0, ovf0}, {WIDTH'(12), CW'(0), 1'b0});
        idle();

        // All channels continuously valid: one accept per cycle, rotating.
        a0 = acc_cnt;
        repeat (4 * N_CH) step(100, 100, 10);
        @(negedge clk);
        #1;
        chk(acc_cnt - a0 == 4 * N_CH, "full_rate", acc_cnt - a0, 4 * N_CH);
        idle();

        // Overflow corners.
        send1(0, mx, WIDTH'(1), 1'b0);
        send1(1 % N_CH, mn, WIDTH'(1), 1'b1);
        send1(N_CH - 1, mx, mx, 1'b0);
        send1(0, mn, mx, 1'b1);
        send1(1, mn, mn, 1'b0);
        send1(0, mx, WIDTH'(-1), 1'b1);
        idle();

        // Backpressure from an empty pipeline.
        a0 = acc_cnt;
        repeat (6) step(100, 0, 10);
        @(negedge clk);
        #1;
        chk(acc_cnt - a0 == LAT, "stall_accepts", acc_cnt - a0, LAT);
        chk(rdy0 == 0, "stall_ready", rdy0, 0);
        idle();

        // Reset with entries in flight.
        repeat (2) step(100, 100, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk(!val0 && !busy0 && !val1 && !busy1, "async_rst",
            {val1, busy1, val0, busy0}, 0);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk(rdy0 == N_CH'(1), "rst_ptr_ch0", rdy0, 1);
        repeat (5) step(100, 100, 0);
        idle();

        // Randomised traffic in chunks of varying load and backpressure.
        for (int k = 0; k < 15; k++) begin
            int pv, pr;
            pv = $urandom_range(100, 10);
            pr = $urandom_range(100, 20);
            repeat (200) step(pv, pr, 25);
        end
        idle();
        chk(q.size() == 0, "scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
